// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared definitions for the iterative InvSubBytes stage: FSM states, block size,
// byte addressing within the 128-bit AES state.
package inv_sub_bytes_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int BLOCK_BYTES = 16;

    // Byte 0 sits at the MSBs (column-major AES state layout).
    function automatic int byte_off(input int i);
        return 127 - 8 * i;
    endfunction

    function automatic bit lanes_ok(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready bus carrying one 128-bit AES state in and the substituted state out.
interface inv_sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/inv_sub_bytes_seq_sub_box.sv
// 8-bit AES inverse S-box lookup, purely combinational.
module sub_box (
    input  logic [7:0] data,
    output logic [7:0] inv_sbox
);
    // Entry 0 is the leftmost byte of the constant.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign inv_sbox = INV_SBOX[data];
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes: LANES bytes of the held state are substituted per cycle,
// so one block takes 16/LANES cycles and uses only LANES S-box instances.
module inv_sub_bytes_seq
    import inv_sub_bytes_seq_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    inv_sub_bytes_seq_if.slave bus
);
    localparam int N        = BLOCK_BYTES / LANES;
    localparam int CW       = (N > 1) ? $clog2(N) : 1;
    localparam bit LANES_OK = lanes_ok(LANES);

    if (!LANES_OK) begin : g_lanes_chk
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [127:0]           work;
    logic                   rdy_q;
    logic                   last;
    logic [LANES-1:0][7:0]  lane_in, lane_out;

    assign last = (cnt == CW'(N - 1));

    always_comb begin
        lane_in = '0;
        for (int k = 0; k < LANES; k++)
            lane_in[k] = work[byte_off(int'(cnt) * LANES + k) -: 8];
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sub_box u_sbox (.data(lane_in[k]), .inv_sbox(lane_out[k]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid && rdy_q) state_nxt = RUN;
            RUN:     if (last)                  state_nxt = DONE;
            DONE:    if (bus.out_ready)         state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            work  <= '0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= (state_nxt == IDLE);
            case (state)
                IDLE: if (bus.in_valid && rdy_q) begin
                    work <= bus.in_state;
                    cnt  <= '0;
                end
                RUN: begin
                    for (int k = 0; k < LANES; k++)
                        work[byte_off(int'(cnt) * LANES + k) -: 8] <= lane_out[k];
                    cnt <= last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_state = work;
endmodule
